// File: rtl/uart_tx_dev_if.sv
// Register bus between the bridge and the UART transmitter.
// No latency of its own: read data is combinational from the addressed register.
// No backpressure: every write strobe is taken on the clock edge where it is high.
interface uart_tx_dev_if;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdin;
    logic [31:0] rdout;

    modport master (output addr, output we, output wdin, input rdout);
    modport slave  (input addr, input we, input wdin, output rdout);
endinterface

// File: rtl/uart_tx_dev.sv
// UART transmitter: byte FIFO, DATA/CTRL/STATUS/DIV registers, 8N1 serializer.
// Latency: a byte written to an empty FIFO with EN=1 starts its start bit one edge later.
// Backpressure: none on the bus; a DATA write into a full FIFO is dropped and flags OVF.
module uart_tx_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          push_vld,
    output logic          push_rdy,
    input  logic [W-1:0]  push_dat,
    output logic          pop_vld,
    input  logic          pop_rdy,
    output logic [W-1:0]  pop_dat,
    output logic [CW-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          full, push_fire, pop_fire;

    assign full      = (count == CW'(DEPTH));
    assign pop_vld   = (count != '0);
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign push_rdy  = !full || pop_rdy;
    assign push_fire = push_vld && push_rdy;
    assign pop_fire  = pop_rdy && pop_vld;
    assign pop_dat   = mem[rptr];

    always_ff @(posedge clk) begin
        if (push_fire) mem[wptr] <= push_dat;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_fire) wptr <= wptr + AW'(1);
            if (pop_fire)  rptr <= rptr + AW'(1);
            case ({push_fire, pop_fire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module uart_tx_dev #(
    parameter logic [15:0] DIV_RESET  = 16'd16,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_dev_if.slave  bus,
    output logic          txd,
    output logic          int_req
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_nx;
    logic [15:0]   div_reg, div_act, bit_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          en, ie, ovf;
    logic          busy, pop, bit_end;
    logic          wr_data, wr_ctrl, wr_div;
    logic          fifo_push_rdy, fifo_vld, fifo_full;
    logic [7:0]    fifo_dat;
    logic [CW-1:0] fifo_cnt;
    logic          unused_wdin;

    assign wr_data     = bus.we && (bus.addr == 2'd0);
    assign wr_ctrl     = bus.we && (bus.addr == 2'd1);
    assign wr_div      = bus.we && (bus.addr == 2'd3);
    assign fifo_full   = (fifo_cnt == CW'(FIFO_DEPTH));
    assign bit_end     = (bit_cnt == div_act - 16'd1);
    assign unused_wdin = ^bus.wdin[31:16];

    uart_tx_fifo #(.W(8), .DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
        .clk      (clk),
        .arst_n   (rst),
        .push_vld (wr_data),
        .push_rdy (fifo_push_rdy),
        .push_dat (bus.wdin[7:0]),
        .pop_vld  (fifo_vld),
        .pop_rdy  (pop),
        .pop_dat  (fifo_dat),
        .count    (fifo_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        busy     = (state != IDLE);
        txd      = 1'b1;
        case (state)
            IDLE: begin
                if (en && fifo_vld) begin
                    pop      = 1'b1;
                    state_nx = START;
                end
            end
            START: begin
                txd = 1'b0;
                if (bit_end) state_nx = DATA;
            end
            DATA: begin
                txd = shreg[0];
                if (bit_end && (bit_idx == 3'd7)) state_nx = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    if (en && fifo_vld) begin
                        pop      = 1'b1;
                        state_nx = START;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // div_act is only refreshed while idle or at a bit boundary, so a DIV
    // write never stretches or shortens the bit in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            div_act <= DIV_RESET;
            int_req <= 1'b0;
        end else begin
            if (pop)                         shreg <= fifo_dat;
            else if (state == DATA && bit_end) shreg <= {1'b0, shreg[7:1]};
            if (state == IDLE || bit_end) begin
                bit_cnt <= '0;
                div_act <= div_reg;
            end else begin
                bit_cnt <= bit_cnt + 16'd1;
            end
            if (state != DATA)   bit_idx <= '0;
            else if (bit_end)    bit_idx <= bit_idx + 3'd1;
            int_req <= ie && !fifo_vld && !busy;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en      <= 1'b0;
            ie      <= 1'b0;
            ovf     <= 1'b0;
            div_reg <= DIV_RESET;
        end else begin
            if (wr_ctrl) begin
                en  <= bus.wdin[0];
                ie  <= bus.wdin[1];
                ovf <= 1'b0;
            end else if (wr_data && !fifo_push_rdy) begin
                ovf <= 1'b1;
            end
            if (wr_div) div_reg <= (bus.wdin[15:0] == 16'd0) ? 16'd1 : bus.wdin[15:0];
        end
    end

    always_comb begin
        bus.rdout = '0;
        case (bus.addr)
            2'd1:    bus.rdout = {30'b0, ie, en};
            2'd2:    bus.rdout = {23'b0, 5'(fifo_cnt), ovf, busy, !fifo_vld, fifo_full};
            2'd3:    bus.rdout = {16'b0, div_reg};
            default: bus.rdout = '0;
        endcase
    end
endmodule

// File: doc/uart_tx_dev.md
UART_TX_DEV -- requirements
Module: uart_tx_dev

Interface
REQ-001 SHALL have parameter DIV_RESET, 16'd16, reset value of the baud divisor (clock cycles per serial bit).
REQ-002 SHALL have parameter FIFO_DEPTH, 4, number of byte entries in the transmit FIFO (power of two).
REQ-003 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port addr  input  2  register select from the bridge: 0 DATA, 1 CTRL, 2 STATUS, 3 DIV.
REQ-006 SHALL have port we  input  1  bridge write strobe, sampled on the rising edge of clk.
REQ-007 SHALL have port wdin  input  32  bridge write data.
REQ-008 SHALL have port rdout  output  32  read data, combinational from addr.
REQ-009 SHALL have port txd  output  1  serial line, idle high.
REQ-010 SHALL have port int_req  output  1  level interrupt request to the bridge hw_int input.

Function
REQ-011 Write DATA SHALL push wdin[7:0] into the FIFO; a read of DATA SHALL return 0.
REQ-012 A DATA write while the FIFO is full SHALL drop the byte and set the sticky OVF flag.
REQ-013 Write CTRL SHALL load EN=wdin[0] and IE=wdin[1], and SHALL clear OVF; a read of CTRL SHALL return {30'b0, IE, EN}.
REQ-014 A read of STATUS SHALL return {23'b0, count[2:0]... zero-extended to bits[8:4], OVF[3], BUSY[2], EMPTY[1], FULL[0]}, where count is the FIFO occupancy 0..FIFO_DEPTH.
REQ-015 Write DIV SHALL load wdin[15:0]; a written value of 0 SHALL be stored as 1; a read of DIV SHALL return {16'b0, div}.
REQ-016 The FSM SHALL have the states IDLE, START, DATA, and STOP; BUSY SHALL be 1 in every state except IDLE.
REQ-017 IDLE->START SHALL occur on the first edge where EN=1 and the FIFO is not empty. On that edge the head byte SHALL be popped into the shift register, and txd SHALL become 0 after that edge.
REQ-018 Every bit SHALL last exactly div clk cycles, counted by a bit counter that restarts at each bit boundary.
REQ-019 A DIV write SHALL take effect at the next bit boundary, never mid-bit.
REQ-020 START SHALL go to DATA, which sends 8 bits LSB first; DATA SHALL then go to STOP, which drives txd=1 for one bit.
REQ-021 From STOP, the FSM SHALL go to START with a fresh pop if EN=1 and the FIFO is not empty, giving back-to-back frames with no idle gap; otherwise it SHALL go to IDLE.
REQ-022 When EN is cleared mid-frame, the current frame SHALL complete and the FSM SHALL then stop in IDLE; FIFO contents SHALL be kept.
REQ-023 A simultaneous push and pop SHALL leave count unchanged and SHALL store the pushed byte; a push into a full FIFO in the same cycle as a pop SHALL be accepted.
REQ-024 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; count SHALL saturate neither below 0 nor above FIFO_DEPTH.
REQ-025 int_req SHALL be IE & EMPTY & ~BUSY, registered with one cycle of latency.

Reset
REQ-026 While rst=0, the block SHALL asynchronously force FSM=IDLE, FIFO empty, pointers=0, EN=0, IE=0, OVF=0, div=DIV_RESET, txd=1, and int_req=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately, with txd=1 while rst=0.
REQ-028 After rst rises, the first edge SHALL behave as a normal operating edge.

Verification
REQ-029 Scenario: DIV=4, CTRL=1, write DATA=0x55 -> txd holds, 4 cycles each: 0,1,0,1,0,1,0,1,0,1; BUSY=1 for 40 cycles, then returns to 0.
REQ-030 Scenario: EN=0, write 5 bytes 0x01..0x05 -> STATUS FULL=1, count=4, OVF=1; after CTRL=1 written, 0x01..0x04 are sent back-to-back and 0x05 is never sent.
REQ-031 Scenario: CTRL=3 (EN and IE) with FIFO empty -> int_req=1; write DATA=0xA0 -> int_req=0 by the following cycle, and int_req=1 again one cycle after the STOP bit ends.
REQ-032 Scenario: write DIV=0 -> DIV reads 1, and each bit lasts 1 cycle.
REQ-033 Scenario: FIFO full, DATA write on the same edge as a pop -> count stays 4, OVF=0, and the new byte is sent last.
REQ-034 Scenario: rst=0 asserted during bit 3 of a frame -> txd=1 immediately, STATUS=0x2, and no further serial activity after release until a new DATA write.
